up_dn_sweep_ctrl: RTL

- Sequencer that drives the 5-bit saturating up/down counter through a programmed sweep.
- Sweep steps: load a start value, step one count at a time toward an end value, wait a programmable dwell between steps, then report completion.
- Sits directly in front of the counter, owns its load/up/down/in inputs, and observes its counter/high/low outputs.

---
 rtl/up_dn_sweep_ctrl_if.sv | 14 +
 rtl/up_dn_sweep_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/up_dn_sweep_ctrl_if.sv
// up_dn_sweep_ctrl_if: control/status bus between the sweep controller and the up/down counter
// master (controller): drives cnt_load, cnt_in, cnt_up, cnt_down; observes cnt_value, cnt_high, cnt_low
// slave (counter): the reverse
interface up_dn_sweep_ctrl_if #(parameter int WIDTH = 5);
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_up;
  logic             cnt_down;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_high;
  logic             cnt_low;
  modport master (output cnt_load, cnt_in, cnt_up, cnt_down, input cnt_value, cnt_high, cnt_low);
  modport slave (input cnt_load, cnt_in, cnt_up, cnt_down, output cnt_value, cnt_high, cnt_low);
endinterface

// File: rtl/up_dn_sweep_ctrl.sv
// up_dn_sweep_ctrl: sweeps a saturating up/down counter from start_val to end_val, one step per dwell+2 cycles
// Ports: clk, rst (async, active high); start/abort requests; start_val/end_val/dwell sweep program;
// busy/done/aborted/dir status; cnt = counter bus (master side), all outputs registered.
module up_dn_sweep_ctrl #(
  parameter int WIDTH   = 5,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   start_val,
  input  logic [WIDTH-1:0]   end_val,
  input  logic [DWELL_W-1:0] dwell,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               dir,
  up_dn_sweep_ctrl_if.master cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, WAIT, STEP, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] cin_q, cin_n, end_q, end_n;
  logic [DWELL_W-1:0] dw_q, dw_n, dcnt, dcnt_n;
  logic dir_n, ab_n, load_q, up_q, down_q;
  always_comb begin
    state_n = state;
    cin_n   = cin_q;
    end_n   = end_q;
    dw_n    = dw_q;
    dcnt_n  = dcnt;
    dir_n   = dir;
    ab_n    = 1'b0;
    if (abort && state != IDLE && state != DONE) begin
      state_n = IDLE;
      ab_n    = 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = LOAD;
          cin_n   = start_val;
          end_n   = end_val;
          dw_n    = dwell;
          dir_n   = end_val > start_val;
        end
        LOAD: state_n = CHECK;
        // a counter pinned at the rail in our direction can never reach end: finish instead of stepping
        CHECK: if (cnt.cnt_value == end_q || (dir ? cnt.cnt_high : cnt.cnt_low)) state_n = DONE;
          else if (dw_q == '0) state_n = STEP;
          else begin
            dcnt_n  = dw_q;
            state_n = WAIT;
          end
        WAIT: begin
          dcnt_n  = dcnt - 1'b1;
          state_n = (dcnt == DWELL_W'(1)) ? STEP : WAIT;
        end
        STEP: state_n = CHECK;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cin_q   <= '0;
      end_q   <= '0;
      dw_q    <= '0;
      dcnt    <= '0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cin_q   <= cin_n;
      end_q   <= end_n;
      dw_q    <= dw_n;
      dcnt    <= dcnt_n;
      dir     <= dir_n;
      busy    <= state_n != IDLE;
      done    <= state_n == DONE;
      aborted <= ab_n;
      load_q  <= state_n == LOAD;
      up_q    <= state_n == STEP && dir_n;
      down_q  <= state_n == STEP && !dir_n;
    end
  end
  assign cnt.cnt_load = load_q;
  assign cnt.cnt_in   = cin_q;
  assign cnt.cnt_up   = up_q;
  assign cnt.cnt_down = down_q;
endmodule
